booth_multiplier_r4: RTL and testbench

- Parametrised radix-4 (modified) Booth sequential multiplier; next generation of the team's 8-bit radix-2 Booth unit.
- Generalised operand width, two mode bits per cycle, runtime signed/unsigned selection, exact most-negative-operand handling.
- Registered product, start/ready/done handshake.
- Sits in the datapath arithmetic cluster, driven by a controller that issues one multiply at a time.

---
 rtl/booth_multiplier_r4.sv | 106 ++++++++++
 tb/tb_booth_multiplier_r4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_r4.sv
// Radix-4 (modified) Booth sequential multiplier with runtime signed/unsigned mode.
// One multiply in flight; start/ready accept, one-cycle done pulse, registered product.
module booth_multiplier_r4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     r,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int E    = WIDTH + 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [E:0]    m_pos, m_neg, m2_pos, m2_neg;
    logic [E:0]    acc, q;
    logic [E:0]    m_ext, addend, sum, acc_nxt, q_nxt;
    logic [E-1:0]  r_ext;
    logic          accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == CALC) && (cnt == LAST);

    // Two guard bits cover the most-negative signed value and all-ones unsigned.
    assign m_ext = signed_mode ? {{3{m[WIDTH-1]}}, m} : {3'b000, m};
    assign r_ext = signed_mode ? {{2{r[WIDTH-1]}}, r} : {2'b00, r};

    always_comb begin
        addend = '0;
        case (q[2:0])
            3'b001, 3'b010: addend = m_pos;
            3'b011:         addend = m2_pos;
            3'b100:         addend = m2_neg;
            3'b101, 3'b110: addend = m_neg;
            default:        addend = '0;
        endcase
    end

    // {A,Q} shifts right by two as one arithmetic register after the add.
    assign sum     = acc + addend;
    assign acc_nxt = {{2{sum[E]}}, sum[E:2]};
    assign q_nxt   = {sum[1:0], q[E:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            m_pos   <= '0;
            m_neg   <= '0;
            m2_pos  <= '0;
            m2_neg  <= '0;
            acc     <= '0;
            q       <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                m_pos  <= m_ext;
                m_neg  <= -m_ext;
                m2_pos <= m_ext << 1;
                m2_neg <= -(m_ext << 1);
                acc    <= '0;
                q      <= {r_ext, 1'b0};
                cnt    <= '0;
            end else if (state == CALC) begin
                acc <= acc_nxt;
                q   <= q_nxt;
                cnt <= last ? '0 : cnt + 1'b1;
            end else if (state == DONE) begin
                cnt <= '0;
            end
            // Low 2*WIDTH bits of the final {A, Q[E:1]}.
            if (last)
                product <= {acc_nxt[WIDTH-3:0], q_nxt[E:1]};
        end
    end
endmodule

// File: tb/tb_booth_multiplier_r4.sv
// Bench for booth_multiplier_r4: directed 8-bit vectors and handshake/reset sequences,
// plus randomized back-to-back 16-bit traffic against an arithmetic reference.
module tb_booth_multiplier_r4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, sm8 = 1'b0, ready8, done8;
    logic [7:0]  m8 = '0, r8 = '0;
    logic [15:0] product8;

    logic        start16 = 1'b0, sm16 = 1'b0, ready16, done16;
    logic [15:0] m16 = '0, r16 = '0;
    logic [31:0] product16;

    booth_multiplier_r4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .m(m8), .r(r8),
        .ready(ready8), .done(done8), .product(product8));

    booth_multiplier_r4 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .m(m16), .r(r16),
        .ready(ready16), .done(done16), .product(product16));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] ref_mul16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        logic [63:0] p;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[31:0];
    endfunction

    // Called at a negedge; issues one 8-bit multiply and checks result, latency and pulse width.
    task automatic mul8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        int lat, n;
        n = 0;
        while (!ready8 && n < 50) begin @(negedge clk); n++; end
        sm8 = sm; m8 = a; r8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin @(negedge clk); lat++; end
        check({tag, " product"}, 32'(product8), 32'(exp));
        check({tag, " latency"}, lat, 5);
        @(negedge clk);
        check({tag, " done width"}, 32'(done8), 0);
        check({tag, " ready back"}, 32'(ready8), 1);
    endtask

    typedef struct {
        string       name;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    localparam int NRAND = 2000;

    initial begin
        vec_t tbl[$];
        logic [31:0] expq[$];
        logic [15:0] prev;
        int issued, got, cyc, last_done;

        tbl.push_back('{"s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000});
        tbl.push_back('{"s -128*1",    1'b1, 8'h80, 8'h01, 16'hFF80});
        tbl.push_back('{"s -1*127",    1'b1, 8'hFF, 8'h7F, 16'hFF81});
        tbl.push_back('{"u 255*255",   1'b0, 8'hFF, 8'hFF, 16'hFE01});
        tbl.push_back('{"s -1*-1",     1'b1, 8'hFF, 8'hFF, 16'h0001});
        tbl.push_back('{"s 127*127",   1'b1, 8'h7F, 8'h7F, 16'h3F01});
        tbl.push_back('{"s -128*-1",   1'b1, 8'h80, 8'hFF, 16'h0080});
        tbl.push_back('{"u 128*128",   1'b0, 8'h80, 8'h80, 16'h4000});
        tbl.push_back('{"u 0*0",       1'b0, 8'h00, 8'h00, 16'h0000});
        tbl.push_back('{"u 200*3",     1'b0, 8'hC8, 8'h03, 16'h0258});

        @(negedge clk);
        check("reset ready", 32'(ready8), 1);
        check("reset done", 32'(done8), 0);
        check("reset product", 32'(product8), 0);
        check("reset product16", product16, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) mul8(tbl[i].name, tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].exp);
        prev = tbl[tbl.size()-1].exp;

        // Handshake: starts during CALC are ignored, operand changes after accept do nothing.
        sm8 = 1'b1; m8 = 8'h80; r8 = 8'h80; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; sm8 = 1'b0; m8 = 8'h11; r8 = 8'h22;
        for (int k = 1; k <= 4; k++) begin
            start8 = (k == 2);
            @(negedge clk);
            check($sformatf("hs ready edge%0d", k), 32'(ready8), 0);
            check($sformatf("hs done edge%0d", k), 32'(done8), 0);
            check($sformatf("hs hold edge%0d", k), 32'(product8), 32'(prev));
        end
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("hs done edge5", 32'(done8), 1);
        check("hs ready edge5", 32'(ready8), 0);
        check("hs product", 32'(product8), 32'h4000);
        @(negedge clk);
        check("hs done edge6", 32'(done8), 0);
        check("hs ready edge6", 32'(ready8), 1);
        @(negedge clk);
        check("hs not queued", 32'(ready8), 1);
        check("hs product held", 32'(product8), 32'h4000);

        // Asynchronous reset in the middle of CALC.
        sm8 = 1'b1; m8 = 8'h80; r8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst ready", 32'(ready8), 1);
        check("rst done", 32'(done8), 0);
        check("rst product", 32'(product8), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mul8("u 7*9", 1'b0, 8'd7, 8'd9, 16'd63);

        // Randomized back-to-back traffic on the 16-bit instance.
        issued = 0; got = 0; cyc = 0; last_done = -1;
        while ((issued < NRAND || expq.size() > 0) && cyc < NRAND * 11 + 200) begin
            @(negedge clk);
            cyc++;
            if (done16) begin
                if (expq.size() > 0) check("rand product", product16, expq.pop_front());
                else check("rand spurious done", 32'(done16), 0);
                if (last_done >= 0) check("rand done spacing", cyc - last_done, 11);
                last_done = cyc;
                got++;
            end
            if (ready16 && issued < NRAND) begin
                sm16 = 1'($urandom_range(0, 1));
                m16 = 16'($urandom);
                r16 = 16'($urandom);
                if (issued < 4) begin
                    m16 = (issued[0]) ? 16'hFFFF : 16'h8000;
                    r16 = m16;
                end
                start16 = 1'b1;
                expq.push_back(ref_mul16(sm16, m16, r16));
                issued++;
            end else begin
                start16 = 1'b0;
            end
        end
        start16 = 1'b0;
        check("rand result count", got, NRAND);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
